// File: rtl/ob_pkg.sv
// rtl/ob_pkg.sv - shared order-book types for the market-order matching datapath
`timescale 1ns/1ps
package ob_pkg;

    typedef logic [15:0] quantity_t;
    typedef logic [15:0] price_t;

    // Exactly one of the three kind flags is set in a well-formed result.
    typedef struct packed {
        logic      mk_ask_lm_bid;
        logic      lm_ask_mk_bid;
        logic      mk_ask_mk_bid;
        logic      ask_consumed;
        logic      bid_consumed;
        price_t    price;
        quantity_t quantity;
        quantity_t remainder;
    } search_result_t;

endpackage

// File: rtl/ob_cntrl_mk_seq.sv
// rtl/ob_cntrl_mk_seq.sv - market-order match sequencer: query, capture, table commands, trade egress
`timescale 1ns/1ps
module ob_cntrl_mk_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   busy,
    output logic                   trade_qry,
    input  logic                   trade_vld_r,
    input  ob_pkg::search_result_t trade_r,
    output logic                   cmd_vld,
    input  logic                   cmd_rdy,
    output logic                   mk_bid_pop,
    output logic                   mk_ask_pop,
    output logic                   lm_bid_pop,
    output logic                   lm_ask_pop,
    output logic                   mk_bid_upd,
    output logic                   mk_ask_upd,
    output logic                   lm_bid_upd,
    output logic                   lm_ask_upd,
    output ob_pkg::quantity_t      upd_quantity,
    output logic                   trade_out_vld,
    output ob_pkg::search_result_t trade_out_r,
    input  logic                   trade_out_rdy,
    output logic [CNT_W-1:0]       trade_cnt_r,
    output logic                   err_r
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QRY,
        S_WAIT,
        S_ISSUE,
        S_SETTLE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    ob_pkg::search_result_t hold_r;
    logic                   cmd_done_r;
    logic                   out_done_r;
    logic [SC_W-1:0]        settle_r;
    logic [7:0]             cmd_r;
    logic [7:0]             dec_cmd;
    ob_pkg::quantity_t      dec_qty;
    logic                   kind_ok;
    logic                   result_ok;
    logic                   result_bad;
    logic                   cmd_hs;
    logic                   out_hs;
    logic                   cmd_fin;
    logic                   out_fin;

    // cmd_r bit order: mk_ask_pop, mk_bid_pop, lm_ask_pop, lm_bid_pop, then the four *_upd in the same order
    assign {mk_ask_pop, mk_bid_pop, lm_ask_pop, lm_bid_pop,
            mk_ask_upd, mk_bid_upd, lm_ask_upd, lm_bid_upd} = cmd_r;

    assign busy        = (state != S_IDLE);
    assign trade_qry   = (state == S_QRY);
    assign trade_out_r = hold_r;

    assign kind_ok    = ($countones({trade_r.mk_ask_lm_bid, trade_r.lm_ask_mk_bid,
                                     trade_r.mk_ask_mk_bid}) == 1);
    assign result_ok  = (state == S_WAIT) && trade_vld_r && kind_ok;
    assign result_bad = (state == S_WAIT) && trade_vld_r && !kind_ok;
    assign cmd_hs     = cmd_vld && cmd_rdy;
    assign out_hs     = trade_out_vld && trade_out_rdy;
    assign cmd_fin    = cmd_done_r || cmd_hs;
    assign out_fin    = out_done_r || out_hs;

    // Map the incoming result's kind and consumed flags onto per-table pop/update commands
    always_comb begin
        logic ask_mk, ask_lm, bid_mk, bid_lm;
        ask_mk  = trade_r.mk_ask_lm_bid || trade_r.mk_ask_mk_bid;
        ask_lm  = trade_r.lm_ask_mk_bid;
        bid_lm  = trade_r.mk_ask_lm_bid;
        bid_mk  = trade_r.lm_ask_mk_bid || trade_r.mk_ask_mk_bid;
        dec_cmd = {ask_mk &&  trade_r.ask_consumed, bid_mk &&  trade_r.bid_consumed,
                   ask_lm &&  trade_r.ask_consumed, bid_lm &&  trade_r.bid_consumed,
                   ask_mk && !trade_r.ask_consumed, bid_mk && !trade_r.bid_consumed,
                   ask_lm && !trade_r.ask_consumed, bid_lm && !trade_r.bid_consumed};
        dec_qty = (|dec_cmd[3:0]) ? trade_r.remainder : '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; en only gates the start of a new query
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (en) state_nxt = S_QRY;
            S_QRY:    state_nxt = S_WAIT;
            S_WAIT:   state_nxt = result_ok ? S_ISSUE : S_IDLE;
            S_ISSUE:  if (cmd_fin && out_fin) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_r == '0) state_nxt = en ? S_QRY : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Capture the trade and launch both outputs together; each drops on its own handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_r        <= '0;
            cmd_vld       <= 1'b0;
            cmd_r         <= '0;
            upd_quantity  <= '0;
            trade_out_vld <= 1'b0;
            cmd_done_r    <= 1'b0;
            out_done_r    <= 1'b0;
        end else if (result_ok) begin
            hold_r        <= trade_r;
            cmd_vld       <= 1'b1;
            cmd_r         <= dec_cmd;
            upd_quantity  <= dec_qty;
            trade_out_vld <= 1'b1;
            cmd_done_r    <= 1'b0;
            out_done_r    <= 1'b0;
        end else begin
            if (cmd_hs) begin
                cmd_vld      <= 1'b0;
                cmd_r        <= '0;
                upd_quantity <= '0;
                cmd_done_r   <= 1'b1;
            end
            if (out_hs) begin
                trade_out_vld <= 1'b0;
                out_done_r    <= 1'b1;
            end
        end
    end

    // Settle countdown between the end of a trade and the next query
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            settle_r <= '0;
        else if (state == S_ISSUE && state_nxt == S_SETTLE)
            settle_r <= SC_W'(SETTLE_CYCLES - 1);
        else if (state == S_SETTLE && settle_r != '0)
            settle_r <= settle_r - SC_W'(1);
    end

    // Saturating executed-trade counter and sticky malformed-result flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trade_cnt_r <= '0;
            err_r       <= 1'b0;
        end else begin
            if (out_hs && trade_cnt_r != '1)
                trade_cnt_r <= trade_cnt_r + CNT_W'(1);
            if (result_bad)
                err_r <= 1'b1;
        end
    end

endmodule

// File: doc/ob_cntrl_mk_seq.md
Name: ob_cntrl_mk_seq

Overview:
Sequencer for the market-order matching datapath. Issues one-cycle trade queries and captures the registered trade result. Converts the result into pop/update commands for the four order tables (market bid/ask queues, limit bid/ask tables) and emits the trade record to egress. After each trade it waits for table state to settle before querying again.

Parameters:
SETTLE_CYCLES, 2, idle cycles after table commands complete before the next query (>=1)
CNT_W, 32, width of the executed-trade counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
en  in  1  matching enable
busy  out  1  FSM not in IDLE
trade_qry  out  1  one-cycle query strobe to the matching datapath
trade_vld_r  in  1  registered result valid, returned 1 cycle after trade_qry
trade_r  in  ob_pkg::search_result_t  registered trade result
cmd_vld  out  1  table command valid
cmd_rdy  in  1  tables accept the command
mk_bid_pop, mk_ask_pop, lm_bid_pop, lm_ask_pop  out  1 each  remove the head/top entry
mk_bid_upd, mk_ask_upd, lm_bid_upd, lm_ask_upd  out  1 each  overwrite the head/top quantity
upd_quantity  out  ob_pkg::quantity_t  new quantity for the asserted *_upd
trade_out_vld  out  1  executed trade valid to egress
trade_out_r  out  ob_pkg::search_result_t  executed trade record
trade_out_rdy  in  1  egress accepts the trade record
trade_cnt_r  out  CNT_W  executed-trade count, saturating
err_r  out  1  sticky malformed-result flag

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; hold register, done flags and counters cleared. Reset mid-trade discards the held trade. No command or trade record is replayed.
- State IDLE: en=1 -> QRY.
- State QRY: trade_qry=1 for exactly one cycle -> WAIT.
- State WAIT: sample trade_vld_r.
  - trade_vld_r=1: capture trade_r into the hold register -> ISSUE.
  - trade_vld_r=0: no tradeable pair -> IDLE. Re-query begins next cycle if en=1, giving a 3-cycle poll period.
- Malformed result: in WAIT, trade_vld_r=1 with the count of {mk_ask_lm_bid, lm_ask_mk_bid, mk_ask_mk_bid} not equal to 1. Set err_r, drop the result, go to IDLE.
- Command decode from the hold register:
  - mk_ask_lm_bid: ask side is mk_ask, bid side is lm_bid.
  - lm_ask_mk_bid: ask side is lm_ask, bid side is mk_bid.
  - mk_ask_mk_bid: ask side is mk_ask, bid side is mk_bid.
  - Per side: *_consumed=1 -> that side's *_pop=1; otherwise that side's *_upd=1.
  - upd_quantity = remainder if any *_upd is asserted, else 0.
  - At most one *_upd is asserted, since only one side can have a remainder. Both sides consumed -> two pops, no upd.
- State ISSUE:
  - cmd_vld and trade_out_vld rise together on the cycle after WAIT.
  - Each is held stable until its own handshake (vld & rdy), then dropped; done flag set.
  - The two handshakes are independent and may complete in the same or different cycles.
  - When both are done -> SETTLE, load settle counter with SETTLE_CYCLES-1.
- State SETTLE: counter decrements each cycle. At 0 -> QRY if en=1, else IDLE.
- en deasserted in QRY/WAIT/ISSUE/SETTLE: the in-flight trade completes normally, then -> IDLE. en only gates new queries from IDLE/SETTLE.
- trade_cnt_r increments by 1 on the trade_out handshake; saturates at 2^CNT_W-1 (no wrap).
- trade_out_r equals the hold register for the whole ISSUE state.
- Command and record outputs are registered; all *_pop/*_upd/upd_quantity are 0 when cmd_vld=0.
- busy = (state != IDLE).
- Minimum trade-to-trade latency with rdy tied high: QRY, WAIT, ISSUE, then SETTLE_CYCLES cycles = 3+SETTLE_CYCLES cycles (5 at default).

Test Plan:
- Reset/idle: rst=0 then 1, en=0 for 20 cycles -> trade_qry never asserted, all outputs 0, busy=0.
- Limit-bid remainder: en=1, rdy=1, result mk_ask_lm_bid, ask_consumed=1, bid_consumed=0, remainder=40 -> one cmd with mk_ask_pop=1, lm_bid_upd=1, upd_quantity=40. trade_out matches the result; trade_cnt_r=1; next trade_qry 5 cycles after the first.
- Market/market equal quantities: mk_ask_mk_bid, both consumed -> mk_ask_pop=1, mk_bid_pop=1, upd_quantity=0, no *_upd asserted.
- Backpressure: cmd_rdy=0 for 3 cycles, trade_out_rdy=0 for 6 cycles -> both outputs held stable. cmd handshakes at cycle 4, trade_out at cycle 7; SETTLE entered only after cycle 7; trade_cnt_r increments once.
- No trade / malformed result: trade_vld_r=0 -> IDLE then re-query every 3 cycles. Result with two kind flags set -> err_r=1 (sticky), no cmd or trade_out issued.
- Abort: assert rst low in ISSUE with cmd_vld=1 -> all outputs 0 immediately (async); after release with en=1 -> fresh trade_qry and no replayed command. With CNT_W=2 after 5 trades -> trade_cnt_r=3.
